// File: rtl/pipe_hazard_unit.sv
// Load-use stall, operand forwarding and branch flush control for the pipelined MIPS datapath.
// Latency: stall/fwd/flush_mask are combinational from the scoreboard and ID inputs; the scoreboard shifts one entry per clock.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX until the youngest matching load becomes forwardable.
module pipe_hazard_unit #(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int BR_STAGE = 1,
    parameter int CNT_W    = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       id_valid,
    input  logic [REG_W-1:0]           id_rs,
    input  logic [REG_W-1:0]           id_rt,
    input  logic                       id_use_rs,
    input  logic                       id_use_rt,
    input  logic [REG_W-1:0]           id_dest,
    input  logic                       id_regwrite,
    input  logic                       id_is_load,
    input  logic                       br_taken,
    output logic                       stall,
    output logic [BR_STAGE:0]          flush_mask,
    output logic [$clog2(DEPTH+1)-1:0] fwd_a,
    output logic [$clog2(DEPTH+1)-1:0] fwd_b,
    output logic [DEPTH-1:0]           sb_valid,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);
    localparam int FWD_W = $clog2(DEPTH + 1);

    // One shadow entry per post-ID pipeline register; index 1 is ID/EX.
    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] dest;
        logic             wr;
        logic             load;
    } sbEntry_t;

    sbEntry_t sbQ [1:DEPTH];
    sbEntry_t sbD [1:DEPTH];

    // Operand 0 is rs, operand 1 is rt.
    logic [1:0][REG_W-1:0] srcReg;
    logic [1:0]            srcUse;
    logic [1:0][FWD_W-1:0] fwdRaw;
    logic [1:0]            hazRaw;
    logic                  stallRaw;
    logic                  flushEff;

    assign srcReg = {id_rt, id_rs};
    assign srcUse = {id_use_rt, id_use_rs};

    // Per-operand lookup: scan oldest to youngest so the youngest match overrides.
    always_comb begin
        fwdRaw = '0;
        hazRaw = '0;
        for (int op = 0; op < 2; op++) begin
            for (int j = DEPTH; j >= 1; j--) begin
                if (sbQ[j].vld && sbQ[j].wr && (sbQ[j].dest == srcReg[op]) &&
                    (srcReg[op] != '0) && srcUse[op]) begin
                    // The producer will sit one entry further on when the consumer reaches EX;
                    // a producer in the last entry is already written to the register file.
                    fwdRaw[op] = (j < DEPTH) ? FWD_W'(j + 1) : '0;
                    hazRaw[op] = sbQ[j].load && ((j + 1) < (2 + LOAD_LAT));
                end
            end
        end
    end

    // Stall/flush arbitration: a branch resolved in ID cannot act while it waits on a load.
    always_comb begin
        stallRaw = id_valid & (|hazRaw);
        flushEff = br_taken & ~((BR_STAGE == 0) & stallRaw);
        stall    = stallRaw & ~flushEff;
        fwd_a    = stall ? '0 : fwdRaw[0];
        fwd_b    = stall ? '0 : fwdRaw[1];
    end

    assign flush_mask = {(BR_STAGE + 1){flushEff & Reset}};

    // Scoreboard next state: shift down, insert ID or a bubble, kill entries younger than the branch.
    always_comb begin
        for (int k = 1; k <= DEPTH; k++) sbD[k] = '0;
        if (!stall) begin
            sbD[1].vld  = id_valid;
            sbD[1].dest = id_dest;
            sbD[1].wr   = id_regwrite;
            sbD[1].load = id_is_load;
        end
        for (int k = 2; k <= DEPTH; k++) sbD[k] = sbQ[k-1];
        if (flushEff) begin
            for (int k = 1; k <= BR_STAGE; k++) sbD[k].vld = 1'b0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int k = 1; k <= DEPTH; k++) sbQ[k] <= '0;
        end else begin
            for (int k = 1; k <= DEPTH; k++) sbQ[k] <= sbD[k];
        end
    end

    // Debug view of the valid bits, bit k-1 for entry k.
    always_comb begin
        sb_valid = '0;
        for (int k = 1; k <= DEPTH; k++) sb_valid[k-1] = sbQ[k].vld;
    end

    // Saturating stall counter.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Saturating flush counter, counting only flushes that take effect.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            flush_cnt <= '0;
        end else if (flushEff && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the pipelined MIPS datapath.
- Keeps a DEPTH-entry shadow scoreboard of the post-ID pipeline registers (entry 1 = ID/EX, entry 2 = EX/MEM, entry 3 = MEM/WB, ...).
- From the scoreboard it generates load-use stalls, per-operand forwarding selects and branch-stage-dependent flush masks.
- Adds stall/flush handling the current pipeline lacks; supports deeper pipelines, variable load latency and selectable branch-resolution stage.

Parameters:
- REG_W, 5, register index width.
- DEPTH, 3, number of tracked post-ID pipeline registers; must be >= 2+LOAD_LAT.
- LOAD_LAT, 1, extra stages after EX/MEM before load data is forwardable.
- BR_STAGE, 1, stage in which br_taken is resolved: 0=ID, 1=EX, 2=MEM; must be < DEPTH.
- CNT_W, 16, performance counter width.

Ports:
- Clk  in  1  clock.
- Reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  real instruction present in ID.
- id_rs, id_rt  in  REG_W each  ID source registers.
- id_use_rs, id_use_rt  in  1 each  source actually read.
- id_dest  in  REG_W  ID destination register, already resolved rt/rd/$31.
- id_regwrite  in  1  ID instruction writes the register file.
- id_is_load  in  1  ID instruction is a load.
- br_taken  in  1  taken control transfer resolved in stage BR_STAGE.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush_mask  out  BR_STAGE+1  bit i clears pipeline register i (0=IF/ID, 1=ID/EX, ...).
- fwd_a, fwd_b  out  clog2(DEPTH+1)  forwarding source registered into ID/EX; 0 = register file, k = pipeline register entry k.
- sb_valid  out  DEPTH  scoreboard valid bits (debug).
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Entry k fields: valid, dest, wr, load.
- Reset (Reset=0, async): all entries invalid; counters 0. Outputs: stall=0, flush_mask=0, fwd_a=fwd_b=0, sb_valid=0.
- Match condition for a source s: entry j matches when valid & wr & dest==s & s!=0 & use_s.
- The youngest (lowest j) match wins; older matches are ignored.
- Forwarding: on match in entry j (j<DEPTH), fwd = j+1, the entry that holds the producer when the consumer is in EX.
  - Match in entry DEPTH, or no match: fwd=0. The register file writes at the clock edge and reads combinationally, so the value is visible next cycle.
- Load-use hazard: matching entry j has load=1 and j+1 < 2+LOAD_LAT.
  - stall = id_valid & hazard on either operand; fwd outputs are then 0.
  - Stall repeats each cycle until the load advances far enough; no internal stall timer.
- Scoreboard update at each posedge:
  - entries k>=2 take entry k-1.
  - entry 1 takes ID info (valid=id_valid) when not stalling; it takes a bubble when stalling.
- Flush (br_taken=1):
  - flush_mask bits 0..BR_STAGE are 1.
  - Next-state entries 1..BR_STAGE are invalid, because the younger instructions are killed.
  - The branch itself moves from entry BR_STAGE to BR_STAGE+1 intact.
  - stall is forced to 0, since the ID instruction is killed anyway.
- Simultaneous stall and br_taken:
  - BR_STAGE>=1: flush wins.
  - BR_STAGE=0 (branch in ID waiting on a load): br_taken is ignored, flush_mask=0, and the controller must re-assert it after the stall clears.
- flush_mask is forced to 0 while Reset=0.
- Counters: stall_cnt += 1 per cycle with stall=1; flush_cnt += 1 per cycle with effective flush. Both hold at 2^CNT_W-1.
- stall, fwd_* and flush_mask are combinational from scoreboard state plus ID/branch inputs. Scoreboard and counters are the only state.

Test Plan:
- Defaults; add $3 (dest 3, ALU) then sub using rs=3 next cycle -> fwd_a=2, stall=0. Next instruction also reading $3 -> fwd_a=3. One more gap -> fwd_a=0.
- lw $5 then add rt=5 immediately -> stall=1 for exactly 1 cycle, entry 1 bubble, then fwd_b=3, stall_cnt=1. With LOAD_LAT=2, DEPTH=4 -> 2 stall cycles, then fwd_b=4.
- Producer dest=0 with regwrite=1, consumer reads $0 -> fwd=0, stall=0.
- Two producers of $7 in entries 1 and 2, consumer reads $7 -> fwd_a=2 (youngest wins).
- BR_STAGE=1: br_taken=1 while a load-use stall is pending -> flush_mask=2'b11, stall=0, entry 1 invalid next cycle, flush_cnt=1. BR_STAGE=0 with stall=1 and br_taken=1 -> flush_mask=0.
- Drive Reset low mid-stream with all entries valid -> sb_valid=0, stall=0, counters 0 immediately, asynchronously without a clock edge. Set CNT_W=2 and hold a stall for 5 cycles -> stall_cnt saturates at 3.
